// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the decode handshake.
// The fetch unit drives through the master modport; memory and decode sit on the slave side.
interface pc_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_instr;

   modport master (
      output imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch; a taken-branch redirect squashes
// whatever is in flight or held for decode and restarts fetch at the word-aligned target.
module pc_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pc_src,
   input  logic [XLEN-1:0] branch_target,
   pc_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t          state, state_next;
   logic [XLEN-1:0] pc, pc_next;
   logic [XLEN-1:0] if_pc_q, if_pc_next;
   logic [XLEN-1:0] if_instr_q, if_instr_next;
   logic            drop, drop_next;
   logic [XLEN-1:0] redirect_pc;

   assign redirect_pc        = {branch_target[XLEN-1:2], 2'b00};

   assign bus.imem_req_valid = (state == REQ);
   assign bus.imem_addr      = pc;
   // A redirect kills the held instruction in the same cycle so decode never takes it
   assign bus.if_valid       = (state == HOLD) && !pc_src;
   assign bus.if_pc          = if_pc_q;
   assign bus.if_instr       = if_instr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         drop       <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         drop       <= drop_next;
         if_pc_q    <= if_pc_next;
         if_instr_q <= if_instr_next;
      end
   end

   // drop marks an accepted request whose response belongs to the wrong path
   always_comb begin
      state_next    = state;
      pc_next       = pc;
      drop_next     = drop;
      if_pc_next    = if_pc_q;
      if_instr_next = if_instr_q;
      case (state)
         IDLE: begin
            state_next = REQ;
            if (pc_src) pc_next = redirect_pc;
         end
         REQ: begin
            if (pc_src) pc_next = redirect_pc;
            if (bus.imem_req_ready) begin
               state_next = WAIT;
               if (pc_src) drop_next = 1'b1;
            end
         end
         WAIT: begin
            if (pc_src) begin
               pc_next = redirect_pc;
               if (bus.imem_rsp_valid) begin
                  drop_next  = 1'b0;
                  state_next = REQ;
               end else begin
                  drop_next = 1'b1;
               end
            end else if (bus.imem_rsp_valid) begin
               if (drop) begin
                  drop_next  = 1'b0;
                  state_next = REQ;
               end else begin
                  if_instr_next = bus.imem_rsp_data;
                  if_pc_next    = pc;
                  pc_next       = pc + XLEN'(4);
                  state_next    = HOLD;
               end
            end
         end
         HOLD: begin
            if (pc_src) begin
               pc_next    = redirect_pc;
               state_next = REQ;
            end else if (bus.if_ready) begin
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
